// File: rtl/picorv_pcpi_arbiter_if.sv
// PCPI bundle shared between the core/units side and the arbiter.
// Unit buses are packed flat: unit i occupies [i*XLEN +: XLEN].
interface picorv_pcpi_arbiter_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUNITS = 2
);
  logic                     pcpi_valid;
  logic                     pcpi_rs1_valid;
  logic                     pcpi_rs2_valid;
  logic                     pcpi_ready;
  logic                     pcpi_wb_write;
  logic [XLEN-1:0]          pcpi_wb_data;
  logic                     pcpi_br_enable;
  logic [XLEN-1:0]          pcpi_br_nextpc;
  logic                     pcpi_trap;
  logic [NUNITS-1:0]        unit_valid;
  logic [NUNITS-1:0]        unit_ready;
  logic [NUNITS-1:0]        unit_wb_write;
  logic [NUNITS*XLEN-1:0]   unit_wb_data;
  logic [NUNITS-1:0]        unit_br_enable;
  logic [NUNITS*XLEN-1:0]   unit_br_nextpc;

  // Core and execution units together.
  modport master (
    output pcpi_valid, pcpi_rs1_valid, pcpi_rs2_valid,
    output unit_ready, unit_wb_write, unit_wb_data, unit_br_enable, unit_br_nextpc,
    input  pcpi_ready, pcpi_wb_write, pcpi_wb_data, pcpi_br_enable, pcpi_br_nextpc, pcpi_trap,
    input  unit_valid
  );

  // Arbiter.
  modport slave (
    input  pcpi_valid, pcpi_rs1_valid, pcpi_rs2_valid,
    input  unit_ready, unit_wb_write, unit_wb_data, unit_br_enable, unit_br_nextpc,
    output pcpi_ready, pcpi_wb_write, pcpi_wb_data, pcpi_br_enable, pcpi_br_nextpc, pcpi_trap,
    output unit_valid
  );
endinterface

// File: rtl/picorv_pcpi_arbiter.sv
// Shares one core PCPI channel among NUNITS execution units with fixed priority
// (index 0 highest) and traps when no unit claims the instruction in time.
module picorv_pcpi_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUNITS  = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        clock,
  input  logic                        resetn,
  picorv_pcpi_arbiter_if.slave        bus,
  output logic [2:0]                  last_grant,
  output logic                        multi_claim
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StTrap  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      last_grant_q, last_grant_d;
  logic            multi_claim_q, multi_claim_d;

  logic [2:0]      sel_idx;
  logic            sel_wb_write, sel_br_enable;
  logic [XLEN-1:0] sel_wb_data, sel_br_nextpc;
  logic            busy, any_ready, grant, rs_ok, multi;

  assign busy      = (state_q == StBusy);
  assign any_ready = |bus.unit_ready;
  assign grant     = busy && bus.pcpi_valid && any_ready;
  assign rs_ok     = bus.pcpi_rs1_valid && bus.pcpi_rs2_valid;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi     = |(bus.unit_ready & (bus.unit_ready - NUNITS'(1)));

  // Descending scan so the lowest claiming index is the one left selected.
  always_comb begin
    sel_idx       = '0;
    sel_wb_write  = 1'b0;
    sel_wb_data   = '0;
    sel_br_enable = 1'b0;
    sel_br_nextpc = '0;
    for (int i = int'(NUNITS) - 1; i >= 0; i--) begin
      if (bus.unit_ready[i]) begin
        sel_idx       = 3'(i);
        sel_wb_write  = bus.unit_wb_write[i];
        sel_wb_data   = bus.unit_wb_data[i*XLEN +: XLEN];
        sel_br_enable = bus.unit_br_enable[i];
        sel_br_nextpc = bus.unit_br_nextpc[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    multi_claim_d = multi_claim_q;
    case (state_q)
      StIdle: begin
        if (bus.pcpi_valid) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (!bus.pcpi_valid) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (any_ready) begin
          state_d      = StIdle;
          cnt_d        = '0;
          last_grant_d = sel_idx;
          if (multi) multi_claim_d = 1'b1;
        end else if (rs_ok) begin
          // Counter holds at CntLast; the trap transition takes over there.
          if (cnt_q == CntLast) state_d = StTrap;
          else                  cnt_d   = cnt_q + 8'd1;
        end
      end
      StTrap:  state_d = StDrain;
      StDrain: if (!bus.pcpi_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_grant_q  <= '0;
      multi_claim_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      multi_claim_q <= multi_claim_d;
    end
  end

  always_comb begin
    bus.unit_valid     = {NUNITS{busy && bus.pcpi_valid}};
    bus.pcpi_ready     = grant;
    bus.pcpi_wb_write  = grant && sel_wb_write;
    bus.pcpi_wb_data   = grant ? sel_wb_data : '0;
    bus.pcpi_br_enable = grant && sel_br_enable;
    bus.pcpi_br_nextpc = grant ? sel_br_nextpc : '0;
    bus.pcpi_trap      = (state_q == StTrap);
  end

  assign last_grant  = last_grant_q;
  assign multi_claim = multi_claim_q;

endmodule

// File: tb/tb_picorv_pcpi_arbiter.sv
// Directed bench for picorv_pcpi_arbiter (XLEN=32, NUNITS=2, TIMEOUT=4).
module tb_picorv_pcpi_arbiter;

  logic       clock;
  logic       resetn;
  logic [2:0] last_grant;
  logic       multi_claim;
  int         checks;
  int         failures;

  picorv_pcpi_arbiter_if #(.XLEN(32), .NUNITS(2)) bus ();

  picorv_pcpi_arbiter #(
    .XLEN    (32),
    .NUNITS  (2),
    .TIMEOUT (4)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus.slave),
    .last_grant  (last_grant),
    .multi_claim (multi_claim)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, checks 4ns later.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic clr();
    bus.pcpi_valid     = 1'b0;
    bus.pcpi_rs1_valid = 1'b0;
    bus.pcpi_rs2_valid = 1'b0;
    bus.unit_ready     = '0;
    bus.unit_wb_write  = '0;
    bus.unit_wb_data   = '0;
    bus.unit_br_enable = '0;
    bus.unit_br_nextpc = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr();
    resetn = 1'b0;
    #3;
    check("rst_unit_valid", 64'(bus.unit_valid), 64'h0);
    check("rst_ready", 64'(bus.pcpi_ready), 64'h0);
    check("rst_trap", 64'(bus.pcpi_trap), 64'h0);
    check("rst_last_grant", 64'(last_grant), 64'h0);
    check("rst_multi", 64'(multi_claim), 64'h0);
    #9 resetn = 1'b1;

    // T1: dispatch, unit 1 completes in c3.
    cyc(); bus.pcpi_valid = 1; bus.pcpi_rs1_valid = 1; bus.pcpi_rs2_valid = 1; #4;
    check("t1_c0_unit_valid", 64'(bus.unit_valid), 64'h0);
    cyc(); #4;
    check("t1_c1_unit_valid", 64'(bus.unit_valid), 64'h3);
    check("t1_c1_ready", 64'(bus.pcpi_ready), 64'h0);
    cyc(); #4;
    cyc();
    bus.unit_ready = 2'b10; bus.unit_wb_write = 2'b10; bus.unit_br_enable = 2'b10;
    bus.unit_wb_data = {32'h0000_1234, 32'hdead_beef};
    bus.unit_br_nextpc = {32'h0000_8000, 32'h0000_4444};
    #4;
    check("t1_ready", 64'(bus.pcpi_ready), 64'h1);
    check("t1_wb_write", 64'(bus.pcpi_wb_write), 64'h1);
    check("t1_wb_data", 64'(bus.pcpi_wb_data), 64'h1234);
    check("t1_br_enable", 64'(bus.pcpi_br_enable), 64'h1);
    check("t1_br_nextpc", 64'(bus.pcpi_br_nextpc), 64'h8000);
    check("t1_trap", 64'(bus.pcpi_trap), 64'h0);
    // Core keeps valid high: forced IDLE cycle must still drop unit_valid.
    cyc(); bus.unit_ready = 2'b00; #4;
    check("t1_c4_last_grant", 64'(last_grant), 64'h1);
    check("t1_c4_unit_valid", 64'(bus.unit_valid), 64'h0);
    check("t1_c4_ready", 64'(bus.pcpi_ready), 64'h0);
    check("t1_c4_wb_data", 64'(bus.pcpi_wb_data), 64'h0);

    // T2: both units ready together; unit 0 wins.
    cyc();
    bus.unit_ready = 2'b11; bus.unit_wb_write = 2'b11;
    bus.unit_wb_data = {32'd9, 32'd5};
    #4;
    check("t2_unit_valid", 64'(bus.unit_valid), 64'h3);
    check("t2_ready", 64'(bus.pcpi_ready), 64'h1);
    check("t2_wb_data", 64'(bus.pcpi_wb_data), 64'h5);
    check("t2_multi_before", 64'(multi_claim), 64'h0);
    cyc(); clr(); #4;
    check("t2_multi", 64'(multi_claim), 64'h1);
    check("t2_last_grant", 64'(last_grant), 64'h0);
    cyc(); cyc(); #4;
    check("t2_multi_sticky", 64'(multi_claim), 64'h1);

    // T3: timeout with operands always valid.
    cyc(); bus.pcpi_valid = 1; bus.pcpi_rs1_valid = 1; bus.pcpi_rs2_valid = 1; #4;
    check("t3_idle_trap", 64'(bus.pcpi_trap), 64'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #4;
      check("t3_busy_trap", 64'(bus.pcpi_trap), 64'h0);
      check("t3_busy_unit_valid", 64'(bus.unit_valid), 64'h3);
    end
    cyc(); #4;
    check("t3_trap", 64'(bus.pcpi_trap), 64'h1);
    check("t3_trap_unit_valid", 64'(bus.unit_valid), 64'h0);
    cyc();
    bus.unit_ready = 2'b01; bus.unit_wb_write = 2'b01; bus.unit_wb_data = {32'd0, 32'h55};
    #4;
    check("t3_drain_trap", 64'(bus.pcpi_trap), 64'h0);
    check("t3_drain_ready", 64'(bus.pcpi_ready), 64'h0);
    check("t3_drain_wb_data", 64'(bus.pcpi_wb_data), 64'h0);
    check("t3_drain_unit_valid", 64'(bus.unit_valid), 64'h0);
    cyc(); clr(); #4;
    cyc(); #4;
    cyc(); bus.pcpi_valid = 1; #4;
    cyc(); #4;
    check("t3_redispatch", 64'(bus.unit_valid), 64'h3);
    cyc(); clr(); #4;

    // T4: rs2 invalid stalls the timeout counter.
    cyc(); bus.pcpi_valid = 1; bus.pcpi_rs1_valid = 1; #4;
    for (int k = 0; k < 10; k++) begin
      cyc(); #4;
      check("t4_stall_trap", 64'(bus.pcpi_trap), 64'h0);
    end
    bus.pcpi_rs2_valid = 1;
    for (int k = 0; k < 2; k++) begin
      cyc(); #4;
      check("t4_valid_trap", 64'(bus.pcpi_trap), 64'h0);
    end
    cyc(); bus.unit_ready = 2'b01; bus.unit_wb_data = {32'd0, 32'h77}; #4;
    check("t4_ready", 64'(bus.pcpi_ready), 64'h1);
    check("t4_wb_data", 64'(bus.pcpi_wb_data), 64'h77);
    check("t4_trap", 64'(bus.pcpi_trap), 64'h0);
    cyc(); clr(); #4;

    // T5: flush in BUSY cycle 2, then a full timeout proves cnt restarted.
    cyc(); bus.pcpi_valid = 1; bus.pcpi_rs1_valid = 1; bus.pcpi_rs2_valid = 1; #4;
    cyc(); #4;
    cyc(); bus.pcpi_valid = 0; bus.unit_ready = 2'b01; bus.unit_wb_data = {32'd0, 32'h66}; #4;
    check("t5_flush_ready", 64'(bus.pcpi_ready), 64'h0);
    check("t5_flush_trap", 64'(bus.pcpi_trap), 64'h0);
    check("t5_flush_unit_valid", 64'(bus.unit_valid), 64'h0);
    cyc(); bus.unit_ready = 2'b00; bus.pcpi_valid = 1; #4;
    check("t5_idle_unit_valid", 64'(bus.unit_valid), 64'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #4;
      check("t5_busy_trap", 64'(bus.pcpi_trap), 64'h0);
    end
    cyc(); #4;
    check("t5_trap", 64'(bus.pcpi_trap), 64'h1);
    cyc(); clr(); #4;
    cyc(); #4;

    // T6: asynchronous reset mid-BUSY while a unit is responding.
    cyc(); bus.pcpi_valid = 1; bus.pcpi_rs1_valid = 1; bus.pcpi_rs2_valid = 1; #4;
    cyc(); bus.unit_ready = 2'b10; bus.unit_wb_data = {32'habcd, 32'd0}; #2;
    check("t6_pre_ready", 64'(bus.pcpi_ready), 64'h1);
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_ready", 64'(bus.pcpi_ready), 64'h0);
    check("t6_rst_wb_data", 64'(bus.pcpi_wb_data), 64'h0);
    check("t6_rst_unit_valid", 64'(bus.unit_valid), 64'h0);
    check("t6_rst_multi", 64'(multi_claim), 64'h0);
    check("t6_rst_last_grant", 64'(last_grant), 64'h0);
    cyc(); clr(); resetn = 1'b1; #4;
    cyc(); bus.pcpi_valid = 1; bus.pcpi_rs1_valid = 1; bus.pcpi_rs2_valid = 1; #4;
    cyc(); bus.unit_ready = 2'b10; bus.unit_wb_data = {32'h4321, 32'd0}; #4;
    check("t6_after_unit_valid", 64'(bus.unit_valid), 64'h3);
    check("t6_after_wb_data", 64'(bus.pcpi_wb_data), 64'h4321);
    cyc(); clr(); #4;
    check("t6_after_last_grant", 64'(last_grant), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
